// File: rtl/fib_sequencer.sv
// Fibonacci control sequencer for the register-file/ALU datapath.
// Issues one datapath micro-op per cycle; control outputs are registered and track the state.
module fib_sequencer #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_REGS   = 16,
   parameter int unsigned SEL_W      = 4,
   parameter int unsigned REG_A      = 0,
   parameter int unsigned REG_B      = 1,
   parameter int unsigned REG_T      = 2,
   parameter int unsigned REG_I      = 3,
   parameter int unsigned REG_N      = 4,
   parameter int unsigned REG_OUT    = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] n_in,
   input  logic [4:0]            flags_in,
   output logic [NUM_REGS-1:0]   w_enable,
   output logic [DATA_WIDTH-1:0] imm_in,
   output logic [7:0]            opcode,
   output logic [SEL_W-1:0]      rdest_sel,
   output logic [SEL_W-1:0]      rsrc_sel,
   output logic                  imm_sel,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow
);

   localparam int unsigned FLAG_L = 4;
   localparam int unsigned FLAG_C = 0;

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_ADDU  = 8'h06;
   localparam logic [7:0] OP_ADDUI = 8'h60;
   localparam logic [7:0] OP_ANDI  = 8'h10;
   localparam logic [7:0] OP_CMP   = 8'h0B;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_CLR_A     = 4'd1,
      S_CLR_B     = 4'd2,
      S_CLR_I     = 4'd3,
      S_CLR_N     = 4'd4,
      S_CLR_OUT   = 4'd5,
      S_SET_B     = 4'd6,
      S_SET_N     = 4'd7,
      S_CHECK     = 4'd8,
      S_ADD_AB    = 4'd9,
      S_MOVE_A    = 4'd10,
      S_MOVE_B    = 4'd11,
      S_INC_I     = 4'd12,
      S_WRITE_OUT = 4'd13,
      S_OVF       = 4'd14,
      S_DONE      = 4'd15
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] n_q, n_d;
   logic                  accept;

   logic [NUM_REGS-1:0]   wen_q, wen_d;
   logic [DATA_WIDTH-1:0] imm_q, imm_d;
   logic [7:0]            opc_q, opc_d;
   logic [SEL_W-1:0]      rdest_q, rdest_d;
   logic [SEL_W-1:0]      rsrc_q, rsrc_d;
   logic                  isel_q, isel_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  ovf_q, ovf_d;

   // Only L and C steer the sequence; the remaining flag bits are don't-care here.
   logic unused_flags;
   assign unused_flags = ^flags_in[3:1];

   function automatic logic [NUM_REGS-1:0] onehot(input int unsigned idx);
      onehot = NUM_REGS'(1) << idx;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         wen_q   <= '0;
         imm_q   <= '0;
         opc_q   <= OP_NOP;
         rdest_q <= '0;
         rsrc_q  <= '0;
         isel_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         wen_q   <= wen_d;
         imm_q   <= imm_d;
         opc_q   <= opc_d;
         rdest_q <= rdest_d;
         rsrc_q  <= rsrc_d;
         isel_q  <= isel_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next state, then the micro-op of that state so the registered outputs line up with state_q.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      wen_d   = '0;
      imm_d   = '0;
      opc_d   = OP_NOP;
      rdest_d = '0;
      rsrc_d  = '0;
      isel_d  = 1'b1;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_CLR_A;
               accept  = 1'b1;
            end
         end
         S_CLR_A:     state_d = S_CLR_B;
         S_CLR_B:     state_d = S_CLR_I;
         S_CLR_I:     state_d = S_CLR_N;
         S_CLR_N:     state_d = S_CLR_OUT;
         S_CLR_OUT:   state_d = S_SET_B;
         S_SET_B:     state_d = S_SET_N;
         S_SET_N:     state_d = S_CHECK;
         S_CHECK:     state_d = flags_in[FLAG_L] ? S_ADD_AB : S_DONE;
         S_ADD_AB:    state_d = flags_in[FLAG_C] ? S_OVF : S_MOVE_A;
         S_MOVE_A:    state_d = S_MOVE_B;
         S_MOVE_B:    state_d = S_INC_I;
         S_INC_I:     state_d = S_WRITE_OUT;
         S_WRITE_OUT: state_d = S_CHECK;
         S_OVF:       state_d = S_DONE;
         default:     state_d = S_IDLE;
      endcase

      n_d = accept ? n_in : n_q;

      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = (state_d == S_DONE);

      // Overflow is sticky across DONE until the next accepted start.
      ovf_d = accept ? 1'b0 : ovf_q;
      if (state_d == S_OVF) begin
         ovf_d = 1'b1;
      end

      case (state_d)
         S_CLR_A: begin
            opc_d = OP_ANDI; rdest_d = SEL_W'(REG_A); isel_d = 1'b0; wen_d = onehot(REG_A);
         end
         S_CLR_B: begin
            opc_d = OP_ANDI; rdest_d = SEL_W'(REG_B); isel_d = 1'b0; wen_d = onehot(REG_B);
         end
         S_CLR_I: begin
            opc_d = OP_ANDI; rdest_d = SEL_W'(REG_I); isel_d = 1'b0; wen_d = onehot(REG_I);
         end
         S_CLR_N: begin
            opc_d = OP_ANDI; rdest_d = SEL_W'(REG_N); isel_d = 1'b0; wen_d = onehot(REG_N);
         end
         S_CLR_OUT: begin
            opc_d = OP_ANDI; rdest_d = SEL_W'(REG_OUT); isel_d = 1'b0; wen_d = onehot(REG_OUT);
         end
         S_SET_B: begin
            opc_d = OP_ADDUI; rdest_d = SEL_W'(REG_B); isel_d = 1'b0;
            imm_d = DATA_WIDTH'(1); wen_d = onehot(REG_B);
         end
         S_SET_N: begin
            opc_d = OP_ADDUI; rdest_d = SEL_W'(REG_N); isel_d = 1'b0;
            imm_d = n_d; wen_d = onehot(REG_N);
         end
         S_CHECK: begin
            opc_d = OP_CMP; rdest_d = SEL_W'(REG_I); rsrc_d = SEL_W'(REG_N); isel_d = 1'b1;
         end
         S_ADD_AB: begin
            opc_d = OP_ADDU; rdest_d = SEL_W'(REG_A); rsrc_d = SEL_W'(REG_B); isel_d = 1'b1;
            wen_d = onehot(REG_T);
         end
         S_MOVE_A: begin
            opc_d = OP_ADDUI; rdest_d = SEL_W'(REG_B); isel_d = 1'b0; wen_d = onehot(REG_A);
         end
         S_MOVE_B: begin
            opc_d = OP_ADDUI; rdest_d = SEL_W'(REG_T); isel_d = 1'b0; wen_d = onehot(REG_B);
         end
         S_INC_I: begin
            opc_d = OP_ADDUI; rdest_d = SEL_W'(REG_I); isel_d = 1'b0;
            imm_d = DATA_WIDTH'(1); wen_d = onehot(REG_I);
         end
         S_WRITE_OUT: begin
            opc_d = OP_ADDUI; rdest_d = SEL_W'(REG_B); isel_d = 1'b0; wen_d = onehot(REG_OUT);
         end
         default: begin
         end
      endcase
   end

   assign w_enable  = wen_q;
   assign imm_in    = imm_q;
   assign opcode    = opc_q;
   assign rdest_sel = rdest_q;
   assign rsrc_sel  = rsrc_q;
   assign imm_sel   = isel_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_fib_sequencer.sv
// Bench for fib_sequencer: drives it against a small register-file/ALU model and checks
// results, latencies and handshake against hand-computed values.
module tb_fib_sequencer;

   localparam int unsigned DW = 16;
   localparam int unsigned NR = 16;
   localparam int unsigned SW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [DW-1:0] n_in;
   logic [4:0]    flags_in;
   logic [NR-1:0] w_enable;
   logic [DW-1:0] imm_in;
   logic [7:0]    opcode;
   logic [SW-1:0] rdest_sel;
   logic [SW-1:0] rsrc_sel;
   logic          imm_sel;
   logic          busy;
   logic          done;
   logic          overflow;

   int n_vec = 0;
   int n_bad = 0;
   int inv_err = 0;

   fib_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .n_in      (n_in),
      .flags_in  (flags_in),
      .w_enable  (w_enable),
      .imm_in    (imm_in),
      .opcode    (opcode),
      .rdest_sel (rdest_sel),
      .rsrc_sel  (rsrc_sel),
      .imm_sel   (imm_sel),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Datapath model: register file plus the five ALU ops the sequencer uses.
   logic [DW-1:0] rf [NR];
   logic [DW-1:0] op_a, op_b, alu_res;
   logic [DW:0]   sum_x;

   always_comb begin
      op_a    = rf[rdest_sel];
      op_b    = imm_sel ? rf[rsrc_sel] : imm_in;
      sum_x   = {1'b0, op_a} + {1'b0, op_b};
      alu_res = '0;
      case (opcode)
         8'h06, 8'h60: alu_res = sum_x[DW-1:0];
         8'h10:        alu_res = op_a & op_b;
         default:      alu_res = '0;
      endcase
      flags_in = {(op_a < op_b), 3'b000, sum_x[DW]};
   end

   always @(posedge clk) begin
      for (int i = 0; i < int'(NR); i++) begin
         if (w_enable[i]) rf[i] <= alu_res;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (!$onehot0(w_enable)) inv_err++;
         if ((opcode == 8'h06 || opcode == 8'h0B) && !imm_sel) inv_err++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One full run; latency counts clock edges from the accept edge up to done.
   task automatic run(input string name, input int n, input int exp_out, input int exp_ovf,
                      input int exp_lat, input int exp_adds, input bit inject);
      int cyc;
      int adds;
      int busy_cnt;
      adds = 0;
      busy_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      n_in  = DW'(n);
      @(posedge clk);
      cyc = 1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < 2000) begin
         if (done) break;
         if (busy) busy_cnt++;
         if (opcode == 8'h06) adds++;
         if (inject && cyc == 20) begin
            start = 1'b1;
            n_in  = DW'(9);
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      chk({name, "_latency"}, 32'(cyc), 32'(exp_lat));
      chk({name, "_done"}, 32'(done), 32'd1);
      chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
      chk({name, "_addu_count"}, 32'(adds), 32'(exp_adds));
      chk({name, "_reg_out"}, 32'(rf[5]), 32'(exp_out));
      chk({name, "_overflow"}, 32'(overflow), 32'(exp_ovf));
      chk({name, "_done_wen"}, 32'(w_enable), 32'd0);
   endtask

   initial begin
      bit found;
      reset = 1'b1;
      start = 1'b0;
      n_in  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_wen", 32'(w_enable), 32'd0);
      chk("rst_opcode", 32'(opcode), 32'h00);
      chk("rst_imm_sel", 32'(imm_sel), 32'd1);
      reset = 1'b0;

      run("n10", 10, 89, 0, 69, 10, 1'b0);
      run("n0", 0, 0, 0, 9, 0, 1'b0);
      run("n24_ovf", 24, 46368, 1, 149, 24, 1'b0);
      run("n3_after_ovf", 3, 3, 0, 27, 3, 1'b0);
      run("n5_busy_start", 5, 8, 0, 39, 5, 1'b1);

      // Reset during MOVE_B of an n=6 run.
      @(negedge clk);
      start = 1'b1;
      n_in  = DW'(6);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (opcode == 8'h60 && rdest_sel == SW'(2) && w_enable == NR'(16'h0002)) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("moveb_seen", 32'(found), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_wen", 32'(w_enable), 32'd0);
      chk("midrst_opcode", 32'(opcode), 32'h00);
      chk("midrst_rdest", 32'(rdest_sel), 32'd0);
      chk("midrst_imm_sel", 32'(imm_sel), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      reset = 1'b0;

      run("n4_after_rst", 4, 5, 0, 33, 4, 1'b0);

      chk("invariants", 32'(inv_err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
